// File: rtl/connect4_pkg.sv
// Shared types and geometry for the connect-four board datapath.
// Holds board dimensions, FSM/player enums and the flat cell-index helper.
package connect4_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FALL  = 2'd1,
        PLACE = 2'd2
    } state_t;

    typedef enum logic {
        RED   = 1'b0,
        GREEN = 1'b1
    } player_t;

    // Flat grid index of row r, 1-based column c.
    function automatic int idx(input int r, input int c);
        return r * COLS + (c - 1);
    endfunction

endpackage

// File: rtl/token_dropper_if.sv
// Bundle between switch decoding, the token dropper and the display/win-checker.
// The master side drives column/drop; the slave side (the dropper) drives everything else.
interface token_dropper_if #(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS
);
    logic [3:0]         column;
    logic               drop;
    logic [ROWS*COLS-1:0] red_grid;
    logic [ROWS*COLS-1:0] green_grid;
    logic               player;
    logic               busy;
    logic               falling_valid;
    logic [2:0]         falling_row;
    logic [3:0]         falling_col;
    logic               placed;
    logic [2:0]         placed_row;
    logic [3:0]         placed_col;
    logic               rejected;

    modport master (
        output column, drop,
        input  red_grid, green_grid, player, busy, falling_valid, falling_row,
               falling_col, placed, placed_row, placed_col, rejected
    );

    modport slave (
        input  column, drop,
        output red_grid, green_grid, player, busy, falling_valid, falling_row,
               falling_col, placed, placed_row, placed_col, rejected
    );
endinterface

// File: rtl/token_dropper_lowest_empty_row.sv
// Finds the lowest empty row of one board column; row 0 has priority.
// full is raised when no row is empty, in which case row reads as 0.
module lowest_empty_row #(
    parameter int ROWS = connect4_pkg::ROWS
) (
    input  logic [ROWS-1:0] occ,
    output logic [2:0]      row,
    output logic            full
);
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        row  = 3'd0;
        full = 1'b1;
        // Scan top-down so the last hit, the lowest empty row, wins.
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!occ[r]) begin
                row  = 3'(r);
                full = 1'b0;
            end
        end
    end
endmodule

// File: rtl/token_dropper.sv
// Accepts a column drop, animates the falling token row by row, then commits it
// to the authoritative red/green occupancy grids and hands the move to the other player.
module token_dropper #(
    parameter int ROWS       = connect4_pkg::ROWS,
    parameter int COLS       = connect4_pkg::COLS,
    parameter int FALL_TICKS = 2
) (
    input  logic            clk,
    input  logic            reset,
    token_dropper_if.slave  bus
);
    import connect4_pkg::*;

    localparam int NCELL  = ROWS * COLS;
    localparam int TICK_W = $clog2(FALL_TICKS + 1);

    state_t             state_q, state_d;
    player_t            player_q, player_d;
    logic [NCELL-1:0]   red_q, red_d, green_q, green_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [2:0]         target_q, target_d;
    logic [2:0]         falling_row_q, falling_row_d;
    logic [3:0]         falling_col_q, falling_col_d;
    logic [2:0]         placed_row_q, placed_row_d;
    logic [3:0]         placed_col_q, placed_col_d;
    logic               rejected_q, rejected_d;

    logic               col_ok;
    int                 sel;
    logic [ROWS-1:0]    occ;
    logic [2:0]         low_row;
    logic               col_full;

    assign col_ok = (bus.column != 4'd0) && (bus.column <= 4'(COLS));

    always_comb begin
        occ = '0;
        sel = col_ok ? int'(bus.column) - 1 : 0;
        for (int r = 0; r < ROWS; r++) begin
            occ[r] = red_q[r*COLS + sel] | green_q[r*COLS + sel];
        end
    end

    lowest_empty_row #(.ROWS(ROWS)) u_lowest (
        .occ  (occ),
        .row  (low_row),
        .full (col_full)
    );

    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        red_d         = red_q;
        green_d       = green_q;
        tick_d        = tick_q;
        target_d      = target_q;
        falling_row_d = falling_row_q;
        falling_col_d = falling_col_q;
        placed_row_d  = placed_row_q;
        placed_col_d  = placed_col_q;
        rejected_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.drop) begin
                    if (!col_ok || col_full) begin
                        rejected_d = 1'b1;
                    end else begin
                        falling_col_d = bus.column;
                        target_d      = low_row;
                        falling_row_d = 3'(ROWS - 1);
                        tick_d        = '0;
                        state_d       = FALL;
                    end
                end
            end
            FALL: begin
                if (tick_q == TICK_W'(FALL_TICKS - 1)) begin
                    if (falling_row_q == target_q) begin
                        // Landing coordinates must already be valid during PLACE.
                        placed_row_d = target_q;
                        placed_col_d = falling_col_q;
                        state_d      = PLACE;
                    end else begin
                        falling_row_d = falling_row_q - 3'd1;
                        tick_d        = '0;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            PLACE: begin
                if (player_q == RED) begin
                    red_d[idx(int'(placed_row_q), int'(placed_col_q))] = 1'b1;
                end else begin
                    green_d[idx(int'(placed_row_q), int'(placed_col_q))] = 1'b1;
                end
                player_d = player_t'(~player_q);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            player_q      <= RED;
            red_q         <= '0;
            green_q       <= '0;
            tick_q        <= '0;
            target_q      <= '0;
            falling_row_q <= '0;
            falling_col_q <= '0;
            placed_row_q  <= '0;
            placed_col_q  <= '0;
            rejected_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            player_q      <= player_d;
            red_q         <= red_d;
            green_q       <= green_d;
            tick_q        <= tick_d;
            target_q      <= target_d;
            falling_row_q <= falling_row_d;
            falling_col_q <= falling_col_d;
            placed_row_q  <= placed_row_d;
            placed_col_q  <= placed_col_d;
            rejected_q    <= rejected_d;
        end
    end

    assign bus.red_grid      = red_q;
    assign bus.green_grid    = green_q;
    assign bus.player        = logic'(player_q);
    assign bus.busy          = (state_q != IDLE);
    assign bus.falling_valid = (state_q == FALL);
    assign bus.falling_row   = falling_row_q;
    assign bus.falling_col   = falling_col_q;
    assign bus.placed        = (state_q == PLACE);
    assign bus.placed_row    = placed_row_q;
    assign bus.placed_col    = placed_col_q;
    assign bus.rejected      = rejected_q;
endmodule

// File: tb/tb_token_dropper.sv
// Self-checking bench for token_dropper: a board-level model predicts every output
// each cycle, and directed scenarios pin the model with hand-computed values.
module tb_token_dropper;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int FT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    token_dropper_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    token_dropper #(.ROWS(ROWS), .COLS(COLS), .FALL_TICKS(FT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Board model: 0 empty, 1 red, 2 green. A move in flight is described by the
    // number of cycles elapsed since acceptance (m_k) against its total fall time (m_n).
    int board [ROWS][COLS];
    bit m_busy, m_rej;
    int m_k, m_n, m_t, m_col, m_player, m_prow, m_pcol;

    always @(posedge clk) begin
        if (reset) begin
            foreach (board[r, c]) board[r][c] = 0;
            m_busy = 0; m_rej = 0; m_k = 0; m_n = 0; m_t = 0;
            m_col = 0; m_player = 0; m_prow = 0; m_pcol = 0;
        end else begin
            m_rej = 0;
            if (!m_busy) begin
                if (bus.drop) begin
                    int c;
                    c = int'(bus.column);
                    if (c < 1 || c > COLS || board[ROWS-1][c-1] != 0) begin
                        m_rej = 1;
                    end else begin
                        int t;
                        t = 0;
                        while (board[t][c-1] != 0) t++;
                        m_busy = 1; m_k = 0; m_t = t; m_col = c;
                        m_n = (ROWS - t) * FT;
                    end
                end
            end else if (m_k < m_n) begin
                m_k++;
                if (m_k == m_n) begin
                    m_prow = m_t;
                    m_pcol = m_col;
                end
            end else begin
                board[m_t][m_col-1] = m_player + 1;
                m_player ^= 1;
                m_busy = 0;
            end
        end
    end

    function automatic logic [63:0] model_grid(input int who);
        logic [63:0] g;
        g = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (board[r][c] == who) g[r*COLS + c] = 1'b1;
        return g;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit fv, pl;
            fv = m_busy && (m_k < m_n);
            pl = m_busy && (m_k == m_n);
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("falling_valid", 64'(bus.falling_valid), 64'(fv));
            check("placed", 64'(bus.placed), 64'(pl));
            check("rejected", 64'(bus.rejected), 64'(m_rej));
            check("player", 64'(bus.player), 64'(m_player));
            check("red_grid", bus.red_grid, model_grid(1));
            check("green_grid", bus.green_grid, model_grid(2));
            check("placed_row", 64'(bus.placed_row), 64'(m_prow));
            check("placed_col", 64'(bus.placed_col), 64'(m_pcol));
            if (fv) check("falling_row", 64'(bus.falling_row), 64'(ROWS - 1 - m_k / FT));
            if (m_busy) check("falling_col", 64'(bus.falling_col), 64'(m_col));
        end
    end

    int fall_cnt = 0, rej_cnt = 0, placed_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (bus.falling_valid === 1'b1) fall_cnt++;
        if (bus.rejected === 1'b1) rej_cnt++;
        if (bus.placed === 1'b1) placed_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
    end

    task automatic drive_drop(input logic [3:0] col);
        @(negedge clk);
        bus.column = col;
        bus.drop   = 1'b1;
        @(negedge clk);
        bus.drop   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    localparam logic [63:0] COL1_MASK = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL2_MASK = 64'h0202_0202_0202_0202;

    initial begin
        int f0, r0, b0, p0;
        reset      = 1'b1;
        bus.column = 4'd0;
        bus.drop   = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_red", bus.red_grid, 64'd0);

        // First token into column 3 lands on row 0 after 16 fall cycles.
        f0 = fall_cnt;
        drive_drop(4'd3);
        check("t1_busy_next", 64'(bus.busy), 64'd1);
        check("t1_row_start", 64'(bus.falling_row), 64'd7);
        wait_idle();
        check("t1_fall_cycles", 64'(fall_cnt - f0), 64'd16);
        check("t1_placed_row", 64'(bus.placed_row), 64'd0);
        check("t1_placed_col", 64'(bus.placed_col), 64'd3);
        check("t1_red_bit2", 64'(bus.red_grid[2]), 64'd1);
        check("t1_player", 64'(bus.player), 64'd1);

        // Second token stacks on row 1 as green.
        f0 = fall_cnt;
        drive_drop(4'd3);
        wait_idle();
        check("t2_fall_cycles", 64'(fall_cnt - f0), 64'd14);
        check("t2_placed_row", 64'(bus.placed_row), 64'd1);
        check("t2_green_bit10", 64'(bus.green_grid[10]), 64'd1);
        check("t2_player", 64'(bus.player), 64'd0);

        // Fill column 1, then one more drop must be refused.
        for (int i = 0; i < ROWS; i++) begin
            drive_drop(4'd1);
            wait_idle();
        end
        check("t3_red_col1", bus.red_grid & COL1_MASK, 64'h0001_0001_0001_0001);
        check("t3_green_col1", bus.green_grid & COL1_MASK, 64'h0100_0100_0100_0100);
        r0 = rej_cnt; b0 = busy_cnt;
        drive_drop(4'd1);
        repeat (3) @(negedge clk);
        check("t3_reject_once", 64'(rej_cnt - r0), 64'd1);
        check("t3_never_busy", 64'(busy_cnt - b0), 64'd0);
        check("t3_player", 64'(bus.player), 64'd0);

        // Out-of-range column codes.
        r0 = rej_cnt;
        drive_drop(4'd0);
        repeat (3) @(negedge clk);
        check("t4_reject_col0", 64'(rej_cnt - r0), 64'd1);
        r0 = rej_cnt;
        drive_drop(4'd9);
        repeat (3) @(negedge clk);
        check("t4_reject_col9", 64'(rej_cnt - r0), 64'd1);
        check("t4_busy", 64'(bus.busy), 64'd0);

        // Drop request while busy is ignored.
        r0 = rej_cnt;
        drive_drop(4'd5);
        repeat (3) @(negedge clk);
        drive_drop(4'd2);
        check("t5_col_held", 64'(bus.falling_col), 64'd5);
        wait_idle();
        check("t5_no_reject", 64'(rej_cnt - r0), 64'd0);
        check("t5_red_bit4", 64'(bus.red_grid[4]), 64'd1);
        check("t5_col2_empty", (bus.red_grid | bus.green_grid) & COL2_MASK, 64'd0);

        // Reset mid-fall discards the token.
        p0 = placed_cnt;
        drive_drop(4'd6);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_falling_valid", 64'(bus.falling_valid), 64'd0);
        check("t6_red", bus.red_grid, 64'd0);
        check("t6_green", bus.green_grid, 64'd0);
        check("t6_player", 64'(bus.player), 64'd0);
        repeat (40) @(negedge clk);
        check("t6_no_placed", 64'(placed_cnt - p0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/token_dropper.md
Name: token_dropper

Overview:
- Consumes the 4-bit column code produced by the switch decoder: 1..8 selects a column, 0 means none or invalid.
- On a drop request, computes the landing row in that column and animates the token falling one row every FALL_TICKS cycles.
- Writes the token into the board state, then toggles the current player.
- Sits between switch decoding and the LED-matrix display and win-checker; it owns the authoritative board occupancy.

Parameters:
ROWS, 8, number of board rows; row 0 is the bottom row.
COLS, 8, number of board columns; valid column codes are 1..COLS.
FALL_TICKS, 2, clock cycles per row step of the fall animation; must be >=1; set large on the board, small in simulation.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
column  input  4  requested column code; 1..COLS valid, 0 means none.
drop  input  1  drop request, sampled only in IDLE; level or pulse, one accept per IDLE visit.
red_grid  output  ROWS*COLS  red occupancy; bit r*COLS+(c-1) is row r, column c.
green_grid  output  ROWS*COLS  green occupancy, same indexing.
player  output  1  current player to move; 0 = red, 1 = green.
busy  output  1  high in FALL and PLACE.
falling_valid  output  1  high in FALL only.
falling_row  output  3  current animated row of the falling token.
falling_col  output  4  latched column of the falling token.
placed  output  1  one-cycle pulse in PLACE.
placed_row  output  3  landing row; held until the next placement.
placed_col  output  4  landing column; held until the next placement.
rejected  output  1  one-cycle pulse for a refused drop.

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE, both grids = 0, player = 0.
  - falling_row, falling_col, placed_row, placed_col = 0.
  - busy, falling_valid, placed, rejected = 0.
  - Reset wins over every other event, including a reset asserted mid-FALL or during PLACE; an in-flight token is discarded.
- States: IDLE, FALL, PLACE.
- IDLE, when drop=1 at an edge:
  - column==0, column>COLS, or the column is full (top row occupied in either grid): rejected=1 for exactly the next cycle; state stays IDLE; grids and player unchanged.
  - Otherwise: latch falling_col=column and target = lowest row empty in both grids for that column. Set falling_row=ROWS-1, tick=0, and go to FALL.
- FALL:
  - tick counts 0..FALL_TICKS-1.
  - At tick==FALL_TICKS-1: if falling_row==target, go to PLACE; else decrement falling_row and set tick=0.
  - Total FALL cycles = (ROWS-target)*FALL_TICKS.
- PLACE (one cycle):
  - placed=1; placed_row=target and placed_col=falling_col, registered and visible in this cycle.
  - At the closing edge: set the grid bit for player (red if 0, green if 1), toggle player, return to IDLE.
  - The new grid bit is visible on the first IDLE cycle.
- drop while busy: ignored, with no rejected and no queuing. If drop is still high on return to IDLE, it is evaluated on that IDLE cycle.
- A cell is never set in both grids. Grid bits only change in PLACE or on reset.
- Width rules:
  - Column codes are compared as unsigned 4-bit values.
  - Row arithmetic is 3-bit unsigned; falling_row never decrements below target, so no wrap.
  - tick is $clog2(FALL_TICKS+1) bits wide.

Decomposition:
- Shared package connect4_pkg holds:
  - ROWS/COLS constants.
  - state_t enum {IDLE, FALL, PLACE}.
  - player_t enum {RED=0, GREEN=1}.
  - A cell-index function idx(r,c)=r*COLS+(c-1).
- One natural combinational sub-module: lowest_empty_row.
  - Inputs: a ROWS-bit column occupancy (red|green).
  - Outputs: row index and full flag.
  - Priority from row 0 upward.

Test Plan (ROWS=8, COLS=8, FALL_TICKS=2):
1. Reset, then drop=1 with column=3 for one cycle:
   - busy=1 next cycle; falling_row goes 7,7,6,6,...,0,0 over 16 cycles.
   - placed=1 with placed_row=0, placed_col=3.
   - Next cycle red_grid[2]=1 and player=1.
2. Second drop on column=3:
   - 14 FALL cycles, placed_row=1.
   - green_grid[10]=1, player=0.
3. Eight drops on column=1 fill it, with alternating colours in bits 0,8,...,56. A ninth drop gives:
   - rejected=1 for one cycle, busy stays 0.
   - Grids and player unchanged.
4. drop with column=0, then with column=9:
   - rejected pulses once each.
   - No state change.
5. During a FALL on column 5, pulse drop with column=2:
   - No rejected, falling_col stays 5.
   - Only column 5 gets a token.
6. Assert reset mid-FALL:
   - Next cycle busy=0, falling_valid=0, both grids=0, player=0.
   - No placed pulse ever appears for the aborted token.
